// File: rtl/pixel_pkg.sv
// Pixel and 3x3 chunk types, window-scheduler state encoding and the border clamp helper
// shared by the window scheduler and its line buffers.
package pixel_pkg;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] grn;
    logic [7:0] blu;
  } pixel_t;

  // [row][col], row 0 is the line above the centre; [1][1] is the centre pixel
  typedef pixel_t [2:0][2:0] chunk_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } win_state_e;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal valid/ready stream interface. A beat transfers on a cycle where vld & rdy
// (exposed as ok); the producer holds vld and data stable until that cycle.
interface axis_if #(
  parameter type T = logic
);
  logic vld;
  logic rdy;
  T     data;
  logic ok;

  assign ok = vld & rdy;

  modport master (output vld, output data, input rdy, input ok);
  modport slave  (input vld, input data, input ok, output rdy);
endinterface

// File: rtl/line_buf.sv
// One-row pixel delay line: the word at addr is read out before being overwritten, so
// dout is the pixel written DEPTH advances earlier.
module line_buf
  import pixel_pkg::*;
#(
  parameter int DEPTH = 640
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  pixel_t                   din,
  output pixel_t                   dout
);

  pixel_t mem_q [DEPTH];

  assign dout = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= din;
  end

endmodule

// File: rtl/conv_window_sched.sv
// Builds a clamped 3x3 neighbourhood per raster pixel and streams it to the conv stage,
// latching the conv enable once per frame from bypass_i.
module conv_window_sched
  import pixel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bypass_i,
  axis_if.slave      axis_i,
  axis_if.master     axis_o,
  output logic       conv_en_o,
  output logic       busy_o,
  output logic       frame_done_o,
  output win_state_e dbg_state_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  win_state_e state_q, state_d;
  logic [CW-1:0] in_col_q, in_col_d, out_col_q, out_col_d;
  logic [RW-1:0] in_row_q, in_row_d, out_row_q, out_row_d;
  logic          vld_q, vld_d, conv_en_q, conv_en_d, fin_q, fin_d;
  chunk_t        data_q, data_d, chunk;
  pixel_t [2:0]  col0_q, col0_d, col1_q, col1_d, new_col;
  pixel_t [2:0][2:0] wc;
  pixel_t        lb1_dout, lb2_dout;
  logic          can_out, in_rdy, in_ok, fill_done, last_in, last_out;
  logic          flush_step, emit, adv;
  logic [1:0]    rsel, csel;

  assign can_out    = !vld_q | axis_o.rdy;
  assign in_ok      = axis_i.ok;
  assign fill_done  = (in_row_q == RW'(1)) && (in_col_q == CW'(1));
  assign last_in    = (in_row_q == RW'(IMG_H - 1)) && (in_col_q == CW'(IMG_W - 1));
  assign last_out   = (out_row_q == RW'(IMG_H - 1)) && (out_col_q == CW'(IMG_W - 1));
  assign flush_step = (state_q == FLUSH) && can_out && !fin_q;
  assign emit       = ((state_q == FILL) && in_ok && fill_done) ||
                      ((state_q == RUN) && in_ok) || flush_step;
  // Line buffers and window keep advancing during flush so the last rows drain out.
  assign adv        = in_ok || flush_step;

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_ok) state_d = FILL;
      FILL:  if (in_ok && fill_done) state_d = last_in ? FLUSH : RUN;
      RUN:   if (in_ok && last_in) state_d = FLUSH;
      FLUSH: if (frame_done_o) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_rdy       = (state_q != FLUSH) && can_out;
    busy_o       = (state_q != IDLE);
    frame_done_o = (state_q == FLUSH) && fin_q && axis_o.ok;
    dbg_state_o  = state_q;
  end

  assign axis_i.rdy = in_rdy;
  assign axis_o.vld = vld_q;
  assign axis_o.data = data_q;
  assign conv_en_o  = conv_en_q;

  line_buf #(.DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .we(adv), .addr(in_col_q), .din(axis_i.data), .dout(lb1_dout)
  );
  line_buf #(.DEPTH(IMG_W)) u_lb2 (
    .clk(clk), .we(adv), .addr(in_col_q), .din(lb1_dout), .dout(lb2_dout)
  );

  // Window columns are [col][row]: col 2 is the arriving column, col 1 holds the centre.
  assign new_col = {axis_i.data, lb1_dout, lb2_dout};
  assign wc      = {new_col, col1_q, col0_q};

  always_comb begin
    chunk = '0;
    rsel  = 2'd1;
    csel  = 2'd1;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        rsel = 2'(clamp(int'(out_row_q) + i - 1, 0, IMG_H - 1) - int'(out_row_q) + 1);
        csel = 2'(clamp(int'(out_col_q) + j - 1, 0, IMG_W - 1) - int'(out_col_q) + 1);
        chunk[i][j] = wc[csel][rsel];
      end
    end
  end

  always_comb begin
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    out_col_d = out_col_q;
    out_row_d = out_row_q;
    vld_d     = vld_q;
    data_d    = data_q;
    fin_d     = fin_q;
    conv_en_d = conv_en_q;
    col0_d    = col0_q;
    col1_d    = col1_q;
    if ((state_q == IDLE) && in_ok) conv_en_d = ~bypass_i;
    if (adv) begin
      col0_d = col1_q;
      col1_d = new_col;
      if (in_col_q == CW'(IMG_W - 1)) begin
        in_col_d = '0;
        in_row_d = (in_row_q == RW'(IMG_H - 1)) ? '0 : in_row_q + RW'(1);
      end else begin
        in_col_d = in_col_q + CW'(1);
      end
    end
    if (emit) begin
      vld_d  = 1'b1;
      data_d = chunk;
      fin_d  = last_out;
      if (out_col_q == CW'(IMG_W - 1)) begin
        out_col_d = '0;
        out_row_d = (out_row_q == RW'(IMG_H - 1)) ? '0 : out_row_q + RW'(1);
      end else begin
        out_col_d = out_col_q + CW'(1);
      end
    end else if (axis_o.ok) begin
      vld_d = 1'b0;
    end
    if (frame_done_o) begin
      in_col_d  = '0;
      in_row_d  = '0;
      out_col_d = '0;
      out_row_d = '0;
      fin_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_col_q  <= '0;
      in_row_q  <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      vld_q     <= 1'b0;
      data_q    <= '0;
      fin_q     <= 1'b0;
      conv_en_q <= 1'b1;
    end else begin
      in_col_q  <= in_col_d;
      in_row_q  <= in_row_d;
      out_col_q <= out_col_d;
      out_row_q <= out_row_d;
      vld_q     <= vld_d;
      data_q    <= data_d;
      fin_q     <= fin_d;
      conv_en_q <= conv_en_d;
    end
  end

  always_ff @(posedge clk) begin
    col0_q <= col0_d;
    col1_q <= col1_d;
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// Bench for conv_window_sched on a 4x3 image: reference neighbourhoods from a pixel array,
// streaming scoreboard, and per-cycle protocol/timing checks.
module tb_conv_window_sched;
  import pixel_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int EW = $bits(chunk_t) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bypass_i = 1'b0;
  logic conv_en_o, busy_o, frame_done_o;
  win_state_e dbg_state;

  axis_if #(.T(pixel_t)) in_if ();
  axis_if #(.T(chunk_t)) out_if ();

  conv_window_sched #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .bypass_i(bypass_i),
    .axis_i(in_if), .axis_o(out_if),
    .conv_en_o(conv_en_o), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];
  pixel_t pix [H][W];

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int lim(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic chunk_t ref_chunk(input int r, input int c);
    chunk_t ch;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        ch[i][j] = pix[lim(r + i - 1, H - 1)][lim(c + j - 1, W - 1)];
    return ch;
  endfunction

  function automatic logic [71:0] red9(input chunk_t ch);
    logic [71:0] v;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[71 - 8 * (3 * i + j) -: 8] = ch[i][j].red;
    return v;
  endfunction

  // ---------------- monitor ----------------
  int cyc = 0, in_cnt = 0, out_cnt = 0, acc5_cyc = 0, first_acc_cyc = 0;
  int done_cyc = 0, done_cnt = 0, stall_cnt = 0, chunk_total = 0;
  logic vld_seen = 1'b0, prev_stall = 1'b0, prev_done = 1'b0, is_ok, is_last;
  chunk_t prev_data;
  chunk_t got_chunk [N];
  int ok_cyc [N];
  logic [EW-1:0] e;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      in_cnt = 0; out_cnt = 0; vld_seen = 1'b0; prev_stall = 1'b0; prev_done = 1'b0;
    end else begin
      is_ok   = out_if.vld & out_if.rdy;
      is_last = is_ok && (out_cnt == N - 1);
      if (prev_stall) begin
        check("hold_vld", out_if.vld, 1);
        check("hold_data", out_if.data, prev_data);
      end
      if (out_if.vld && !out_if.rdy) begin
        stall_cnt++;
        check("in_rdy_bp", in_if.rdy, 0);
      end
      if (in_cnt == N) check("flush_in_rdy", in_if.rdy, 0);
      if (prev_done) check("busy_fall", busy_o, 0);
      if (frame_done_o || is_last) begin
        check("done_on_last", {frame_done_o, is_last}, 2'b11);
        check("busy_at_done", busy_o, 1);
      end
      if (out_if.vld && !vld_seen) begin
        check("first_vld_lat", cyc, acc5_cyc + 1);
        vld_seen = 1'b1;
      end
      if (is_ok) begin
        if (exp_q.size() == 0) check("extra_chunk", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("chunk", {conv_en_o, out_if.data}, e);
        end
        if (out_cnt < N) begin
          got_chunk[out_cnt] = out_if.data;
          ok_cyc[out_cnt] = cyc;
        end
        out_cnt++;
        chunk_total++;
      end
      if (in_if.vld && in_if.rdy) begin
        if (in_cnt == 0) first_acc_cyc = cyc;
        if (in_cnt == W + 1) acc5_cyc = cyc;
        in_cnt++;
      end
      prev_stall = out_if.vld & ~out_if.rdy;
      prev_data  = out_if.data;
      prev_done  = frame_done_o;
      if (frame_done_o) begin
        done_cyc = cyc; done_cnt++;
        in_cnt = 0; out_cnt = 0; vld_seen = 1'b0;
      end
    end
  end

  // ---------------- drivers ----------------
  int gap_max = 0;
  int rdy_mode = 0;

  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode != 0) out_if.rdy = 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_pix(input pixel_t p, input logic byp);
    int budget;
    logic acc;
    repeat ($urandom_range(0, gap_max)) step();
    in_if.vld = 1'b1; in_if.data = p; bypass_i = byp;
    budget = 200; acc = 1'b0;
    while (!acc && budget > 0) begin
      @(negedge clk); acc = in_if.rdy & rst;
      step(); budget--;
    end
    in_if.vld = 1'b0;
    check("in_accept", acc, 1);
  endtask

  task automatic drive_frame(input int kind, input logic byp, input logic tog, input int stop_at);
    pixel_t p;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (kind == 0) p = '{red: 8'(4 * r + c), grn: 8'd0, blu: 8'd0};
        else p = 24'($urandom);
        pix[r][c] = p;
      end
    for (int k = 0; k < N; k++) exp_q.push_back({~byp, ref_chunk(k / W, k % W)});
    for (int k = 0; k < N; k++) begin
      if (k == stop_at) return;
      drive_pix(pix[k / W][k % W], (k == 0 || !tog) ? byp : 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic wait_done(input int target);
    int budget = 600;
    while (done_cnt < target && budget > 0) begin step(); budget--; end
    check("frame_done_seen", done_cnt >= target, 1);
  endtask

  task automatic wait_out(input int n);
    int budget = 200;
    while (out_cnt < n && budget > 0) begin step(); budget--; end
    check("out_progress", out_cnt >= n, 1);
  endtask

  localparam logic [71:0] C00 = {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd4, 8'd4, 8'd5};
  localparam logic [71:0] C13 = {8'd2, 8'd3, 8'd3, 8'd6, 8'd7, 8'd7, 8'd10, 8'd11, 8'd11};
  localparam logic [71:0] C20 = {8'd4, 8'd4, 8'd5, 8'd8, 8'd8, 8'd9, 8'd8, 8'd8, 8'd9};

  initial begin
    int s0, d0;
    in_if.vld = 1'b0; in_if.data = '0; out_if.rdy = 1'b1;
    repeat (2) step();
    check("rst_vld", out_if.vld, 0);
    check("rst_data", out_if.data, 0);
    check("rst_en", conv_en_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_done", frame_done_o, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b1;
    step();

    // full frame, no backpressure
    drive_frame(0, 1'b0, 1'b0, -1);
    wait_done(1);
    check("chunk_0_0", red9(got_chunk[0]), C00);
    check("chunk_1_3", red9(got_chunk[7]), C13);
    check("chunk_2_0", red9(got_chunk[8]), C20);
    check("flush_consecutive", ok_cyc[N - 1] - ok_cyc[N - W - 2], W + 1);
    check("q_empty_1", exp_q.size(), 0);

    // backpressure mid-RUN
    s0 = stall_cnt; d0 = chunk_total;
    fork
      drive_frame(0, 1'b0, 1'b0, -1);
      begin
        wait_out(4);
        out_if.rdy = 1'b0;
        repeat (3) step();
        out_if.rdy = 1'b1;
      end
    join
    wait_done(2);
    check("bp_stalls", stall_cnt - s0, 3);
    check("bp_count", chunk_total - d0, N);
    check("q_empty_2", exp_q.size(), 0);

    // bypass latched at first pixel, toggling ignored; then enabled frame
    drive_frame(0, 1'b1, 1'b1, -1);
    wait_done(3);
    drive_frame(0, 1'b0, 1'b1, -1);
    wait_done(4);
    check("q_empty_3", exp_q.size(), 0);

    // reset mid-frame after 7 inputs (bypassed frame so the enable reset is visible)
    d0 = done_cnt;
    drive_frame(0, 1'b1, 1'b0, 7);
    check("pre_rst_en", conv_en_o, 0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_vld", out_if.vld, 0);
    check("mid_rst_data", out_if.data, 0);
    check("mid_rst_en", conv_en_o, 1);
    check("mid_rst_busy", busy_o, 0);
    exp_q.delete();
    step(); step();
    rst = 1'b1;
    step();
    check("no_done_on_rst", done_cnt, d0);
    drive_frame(0, 1'b0, 1'b0, -1);
    wait_done(d0 + 1);
    check("rst_chunk_0_0", red9(got_chunk[0]), C00);
    check("rst_chunk_2_0", red9(got_chunk[8]), C20);

    // back-to-back frames
    drive_frame(0, 1'b0, 1'b0, -1);
    drive_frame(0, 1'b0, 1'b0, -1);
    check("b2b_first_acc", first_acc_cyc, done_cyc + 1);
    wait_done(d0 + 3);
    check("b2b_chunk_0_0", red9(got_chunk[0]), C00);

    // randomized pixels, gaps, backpressure and bypass
    d0 = done_cnt;
    gap_max = 2; rdy_mode = 1;
    for (int f = 0; f < 4; f++) drive_frame(1, 1'($urandom_range(0, 1)), 1'b1, -1);
    wait_done(d0 + 3);
    rdy_mode = 0; out_if.rdy = 1'b1;
    wait_done(d0 + 4);
    check("q_empty_end", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
